// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the 8-entry register file write port (ALU port A vs. load port B).
// Registers a one-hot write enable and write data one cycle after the grant, and counts contention cycles.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [2:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [2:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [7:0]        we,
  output logic [DATA_W-1:0] wd,
  output logic [CNT_W-1:0]  contend_cnt
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic              xfer;
  logic [2:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [7:0]        we_d;
  logic              contend;
  logic [7:0]        we_q;
  logic [DATA_W-1:0] wd_q;
  logic [CNT_W-1:0]  cnt_q;

  // The pointer only breaks ties; a lone requester is always granted.
  assign a_ready = ~hold & a_valid & (~b_valid | (ptr_q == PTR_A));
  assign b_ready = ~hold & b_valid & (~a_valid | (ptr_q == PTR_B));
  assign contend = ~hold & a_valid & b_valid;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ptr_d    = ptr_q;
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (a_ready) begin
      ptr_d    = PTR_B;
      xfer     = 1'b1;
      sel_addr = a_addr;
      sel_data = a_data;
    end else if (b_ready) begin
      ptr_d    = PTR_A;
      xfer     = 1'b1;
      sel_addr = b_addr;
      sel_data = b_data;
    end
  end

  always_comb begin
    we_d = '0;
    if (xfer) we_d[sel_addr] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_A;
      we_q  <= '0;
      wd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      if (xfer) wd_q <= sel_data;
      if (contend && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign we          = we_q;
  assign wd          = wd_q;
  assign contend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected {we,wd} into a queue,
// a negedge monitor pops and compares whenever the DUT presents a write.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic       a_valid, b_valid;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic [7:0] we, wd, contend_cnt;
  logic       a_ready2, b_ready2;
  logic [7:0] we2, wd2;
  logic [1:0] contend_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .wd(wd), .contend_cnt(contend_cnt)
  );

  // Narrow counter instance sharing the same stimulus, used for saturation.
  regfile_write_arbiter #(.DATA_W(8), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready2),
    .we(we2), .wd(wd2), .contend_cnt(contend_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any write presented by the DUT must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && (we != 8'h00)) begin
      check("we_onehot", {31'd0, $onehot(we)}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_we", {24'd0, we}, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("we", {24'd0, we}, {24'd0, e[15:8]});
        check("wd", {24'd0, wd}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic step(input logic h,
                      input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                      input logic exp_ar, input logic exp_br,
                      input logic [7:0] exp_we, input logic [7:0] exp_wd);
    hold = h;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(negedge clk);
    check("a_ready", {31'd0, a_ready}, {31'd0, exp_ar});
    check("b_ready", {31'd0, b_ready}, {31'd0, exp_br});
    @(posedge clk);
    #1;
    if (exp_ar || exp_br) exp_q.push_back({exp_we, exp_wd});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Asynchronous reset pulse placed 1 time unit after an edge; anything queued is dropped.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_we", {24'd0, we}, 32'd0);
    check("rst_wd", {24'd0, wd}, 32'd0);
    check("rst_cnt", {24'd0, contend_cnt}, 32'd0);
    check("rst_cnt_sat", {30'd0, contend_cnt2}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b1; a_addr = 3'd2; a_data = 8'h5A;
    b_valid = 1'b0; b_addr = 3'd0; b_data = 8'h00;
    #2;
    check("init_we", {24'd0, we}, 32'd0);
    check("init_wd", {24'd0, wd}, 32'd0);
    check("init_cnt", {24'd0, contend_cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // A held valid through reset is granted at the first edge after release.
    step(1'b0, 1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h04, 8'h5A);

    // A only: addr 5, data 3C, then idle keeps wd.
    step(1'b0, 1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h3C);
    idle();
    check("idle_we", {24'd0, we}, 32'd0);
    check("idle_wd_hold", {24'd0, wd}, 32'h3C);
    check("idle_cnt", {24'd0, contend_cnt}, 32'd0);

    // Round robin from reset: A,B,A,B.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        step(1'b0, 1'b1, 3'd1, 8'hA1, 1'b1, 3'd6, 8'hB6, 1'b1, 1'b0, 8'h02, 8'hA1);
      else
        step(1'b0, 1'b1, 3'd1, 8'hA1, 1'b1, 3'd6, 8'hB6, 1'b0, 1'b1, 8'h40, 8'hB6);
    end
    idle();
    check("rr_cnt", {24'd0, contend_cnt}, 32'd4);
    check("rr_queue_empty", exp_q.size(), 32'd0);

    // Leave pointer on B, then stall with both valid.
    step(1'b0, 1'b1, 3'd0, 8'h0F, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 3'd4, 8'h44, 1'b1, 3'd7, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
      check("hold_we", {24'd0, we}, 32'd0);
    end
    check("hold_cnt", {24'd0, contend_cnt}, 32'd4);
    check("hold_wd", {24'd0, wd}, 32'h0F);
    step(1'b0, 1'b1, 3'd4, 8'h44, 1'b1, 3'd7, 8'h77, 1'b0, 1'b1, 8'h80, 8'h77);
    step(1'b0, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h44);
    idle();
    check("post_hold_cnt", {24'd0, contend_cnt}, 32'd5);
    check("post_hold_queue_empty", exp_q.size(), 32'd0);

    // Move pointer to A, then same destination from both ports.
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h55, 1'b0, 1'b1, 8'h20, 8'h55);
    step(1'b0, 1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 8'h22, 1'b1, 1'b0, 8'h08, 8'h11);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h22, 1'b0, 1'b1, 8'h08, 8'h22);
    idle();
    check("same_addr_wd", {24'd0, wd}, 32'h22);
    check("same_addr_cnt", {24'd0, contend_cnt}, 32'd6);
    check("same_addr_queue_empty", exp_q.size(), 32'd0);

    // Saturation on the 2-bit counter, then asynchronous reset mid-sequence.
    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(1'b0, 1'b1, 3'd1, 8'hA1, 1'b1, 3'd6, 8'hB6, 1'b1, 1'b0, 8'h02, 8'hA1);
      else
        step(1'b0, 1'b1, 3'd1, 8'hA1, 1'b1, 3'd6, 8'hB6, 1'b0, 1'b1, 8'h40, 8'hB6);
      check("sat_cnt2", {30'd0, contend_cnt2}, (i < 3) ? (i + 1) : 3);
      check("sat_cnt8", {24'd0, contend_cnt}, i + 1);
    end
    // Last B transfer is pending in we; reset must drop it.
    reset_pulse();
    idle();
    check("final_we", {24'd0, we}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
